sobel_edge_avalon_st: RTL



---
 rtl/sobel_pkg.sv | 41 ++++
 rtl/sobel_line_buffer.sv | 26 ++
 rtl/sobel_edge_avalon_st.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types, widths and the Sobel kernel for the edge-magnitude filter.
// The kernel works on a 3x3 window indexed [row][col], with [0][0] at the top-left.
package sobel_pkg;

    localparam int PIX_W   = 8;
    localparam int GRAD_W  = 11;
    localparam int MAG_W   = 12;
    localparam int MAX_PIX = 255;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [2:0][2:0] win_t;

    function automatic logic signed [GRAD_W-1:0] ext(input pix_t v);
        return signed'(GRAD_W'(v));
    endfunction

    function automatic pix_t sobel_kernel(input win_t p, input int unsigned threshold);
        logic signed [GRAD_W-1:0] gx;
        logic signed [GRAD_W-1:0] gy;
        logic [MAG_W-1:0]         ax;
        logic [MAG_W-1:0]         ay;
        logic [MAG_W-1:0]         mag;
        gx = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
           - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
        gy = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
           - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
        ax  = (gx < 0) ? MAG_W'(-gx) : MAG_W'(gx);
        ay  = (gy < 0) ? MAG_W'(-gy) : MAG_W'(gy);
        mag = ax + ay;
        if (threshold == 0) begin
            return (mag > MAG_W'(MAX_PIX)) ? PIX_W'(MAX_PIX) : mag[PIX_W-1:0];
        end
        return (32'(mag) >= threshold) ? PIX_W'(MAX_PIX) : '0;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel history: asynchronous read, synchronous write, so a read and
// write at the same address in one cycle returns the previous contents.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [0:DEPTH-1];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_edge_avalon_st.sv
// 3x3 Sobel edge-magnitude filter on an 8-bit Avalon-ST gray stream; emits one
// pixel per interior input pixel with SOP/EOP regenerated for the interior frame.
module sobel_edge_avalon_st
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 640,
    parameter int unsigned THRESHOLD = 0
) (
    input  logic             csi_clock_reset_clk,
    input  logic             csi_clock_reset_reset_n,
    input  logic [PIX_W-1:0] asi_sink1_data,
    input  logic             asi_sink1_startofpacket,
    input  logic             asi_sink1_endofpacket,
    input  logic             asi_sink1_valid,
    output logic             asi_sink1_ready,
    output logic [PIX_W-1:0] aso_source1_data,
    output logic             aso_source1_startofpacket,
    output logic             aso_source1_endofpacket,
    output logic             aso_source1_valid,
    input  logic             aso_source1_ready
);

    localparam int unsigned      COL_W    = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_next;
    logic [COL_W-1:0] pix_col;
    logic [1:0]       row;
    logic [1:0]       row_next;
    logic [1:0]       pix_row;
    logic             first_pending;
    logic             first_pending_next;
    logic             accept;
    logic             process;
    logic             produce;
    pix_t             lb1_rd;
    pix_t             lb2_rd;
    pix_t [2:0]       win_c0;
    pix_t [2:0]       win_c1;
    pix_t [2:0]       win_c2;
    win_t             window;
    pix_t             edge_pix;

    assign asi_sink1_ready = aso_source1_ready | ~aso_source1_valid;
    assign accept          = asi_sink1_valid & asi_sink1_ready;

    // An SOP pixel is always coordinate (0,0), whatever the counters say.
    always_comb begin
        state_next         = state;
        col_next           = col;
        row_next           = row;
        first_pending_next = first_pending;
        process            = 1'b0;
        produce            = 1'b0;
        pix_col            = col;
        pix_row            = row;
        if (accept) begin
            if (asi_sink1_startofpacket) begin
                pix_col            = '0;
                pix_row            = '0;
                first_pending_next = 1'b1;
            end
            process = asi_sink1_startofpacket | (state == ACTIVE);
            if (process) begin
                produce    = (pix_row == 2'd2) && (pix_col >= COL_W'(2));
                state_next = ACTIVE;
                if (produce) begin
                    first_pending_next = 1'b0;
                end
                if (asi_sink1_endofpacket) begin
                    col_next   = '0;
                    row_next   = '0;
                    state_next = IDLE;
                end else if (pix_col == LAST_COL) begin
                    col_next = '0;
                    row_next = (pix_row == 2'd2) ? 2'd2 : pix_row + 2'd1;
                end else begin
                    col_next = pix_col + COL_W'(1);
                    row_next = pix_row;
                end
            end
        end
    end

    always_ff @(posedge csi_clock_reset_clk or negedge csi_clock_reset_reset_n) begin
        if (!csi_clock_reset_reset_n) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            first_pending <= 1'b0;
        end else begin
            state         <= state_next;
            col           <= col_next;
            row           <= row_next;
            first_pending <= first_pending_next;
        end
    end

    // lb1 holds row r-1, lb2 holds row r-2; lb1's old word cascades into lb2.
    sobel_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk     (csi_clock_reset_clk),
        .we      (process),
        .addr    (pix_col),
        .wr_data (asi_sink1_data),
        .rd_data (lb1_rd)
    );

    sobel_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (COL_W)
    ) u_lb2 (
        .clk     (csi_clock_reset_clk),
        .we      (process),
        .addr    (pix_col),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    assign win_c2 = {asi_sink1_data, lb1_rd, lb2_rd};

    always_ff @(posedge csi_clock_reset_clk or negedge csi_clock_reset_reset_n) begin
        if (!csi_clock_reset_reset_n) begin
            win_c0 <= '0;
            win_c1 <= '0;
        end else if (process) begin
            win_c0 <= win_c1;
            win_c1 <= win_c2;
        end
    end

    always_comb begin
        window = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            window[r][0] = win_c0[r];
            window[r][1] = win_c1[r];
            window[r][2] = win_c2[r];
        end
    end

    assign edge_pix = sobel_kernel(window, THRESHOLD);

    always_ff @(posedge csi_clock_reset_clk or negedge csi_clock_reset_reset_n) begin
        if (!csi_clock_reset_reset_n) begin
            aso_source1_valid         <= 1'b0;
            aso_source1_data          <= '0;
            aso_source1_startofpacket <= 1'b0;
            aso_source1_endofpacket   <= 1'b0;
        end else if (produce) begin
            aso_source1_valid         <= 1'b1;
            aso_source1_data          <= edge_pix;
            aso_source1_startofpacket <= first_pending;
            aso_source1_endofpacket   <= asi_sink1_endofpacket;
        end else if (aso_source1_ready) begin
            aso_source1_valid <= 1'b0;
        end
    end

endmodule
